// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer blocks (write and read side).
package fifo_pkg;

   localparam int ADDRSIZE_DEF = 5;

   typedef logic [ADDRSIZE_DEF:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return (b >> 1) ^ b;
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b = '0;
      for (int i = 0; i <= ADDRSIZE_DEF; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side pointer/status bundle between the write-domain user and wptr_full.
interface wptr_full_if
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE = ADDRSIZE_DEF
);
   logic                winc;
   logic [ADDRSIZE:0]   wq2_rptr;
   logic                wovf_clr;
   logic [ADDRSIZE-1:0] waddr;
   logic [ADDRSIZE:0]   wptr;
   logic                wfull;
   logic                walmost_full;
   logic [ADDRSIZE:0]   wlevel;
   logic                woverflow;

   modport master (
      output winc, wq2_rptr, wovf_clr,
      input  waddr, wptr, wfull, walmost_full, wlevel, woverflow
   );

   modport slave (
      input  winc, wq2_rptr, wovf_clr,
      output waddr, wptr, wfull, walmost_full, wlevel, woverflow
   );
endinterface

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above it.
module gray2bin_conv
   import fifo_pkg::*;
#(
   parameter int W = ADDRSIZE_DEF + 1
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   // XOR-prefix from the MSB down
   always_comb begin
      bin = '0;
      for (int i = 0; i < W; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/wptr_full.sv
// Write pointer and full/almost-full/level/overflow status for the dual-clock FIFO.
// Status is computed against the synchronised read pointer, so it is pessimistic:
// wfull releases and wlevel drops only after a read crosses the synchroniser.
module wptr_full
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE     = ADDRSIZE_DEF,
   parameter int AFULL_THRESH = 2**ADDRSIZE - 4
) (
   input  logic       wclk,
   input  logic       wrst,
   wptr_full_if.slave bus
);

   localparam logic [ADDRSIZE:0] AFULL_LVL = AFULL_THRESH[ADDRSIZE:0];

   logic [ADDRSIZE:0] wbin;
   logic [ADDRSIZE:0] wbinnext;
   logic [ADDRSIZE:0] wgraynext;
   logic [ADDRSIZE:0] rbin_s;
   logic [ADDRSIZE:0] wlevel_next;
   logic [ADDRSIZE:0] rptr_wrapped;
   logic              we;
   logic              wfull_val;

   gray2bin_conv #(.W(ADDRSIZE + 1)) u_rptr_conv (
      .gray (bus.wq2_rptr),
      .bin  (rbin_s)
   );

   // Next pointer, full detection and fill level from the synchronised read pointer
   always_comb begin
      we           = bus.winc & ~bus.wfull;
      wbinnext     = wbin + {{ADDRSIZE{1'b0}}, we};
      wgraynext    = (wbinnext >> 1) ^ wbinnext;
      // Full means the write pointer has lapped the read pointer exactly once
      rptr_wrapped = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
      wfull_val    = (wgraynext == rptr_wrapped);
      wlevel_next  = wbinnext - rbin_s;
   end

   // Pointer and status registers
   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin             <= '0;
         bus.wptr         <= '0;
         bus.wfull        <= 1'b0;
         bus.wlevel       <= '0;
         bus.walmost_full <= 1'b0;
      end else begin
         wbin             <= wbinnext;
         bus.wptr         <= wgraynext;
         bus.wfull        <= wfull_val;
         bus.wlevel       <= wlevel_next;
         bus.walmost_full <= (wlevel_next >= AFULL_LVL);
      end
   end

   // Sticky overflow; a rejected write wins over a simultaneous clear
   always_ff @(posedge wclk) begin
      if (wrst) begin
         bus.woverflow <= 1'b0;
      end else if (bus.winc && bus.wfull) begin
         bus.woverflow <= 1'b1;
      end else if (bus.wovf_clr) begin
         bus.woverflow <= 1'b0;
      end
   end

   assign bus.waddr = wbin[ADDRSIZE-1:0];

endmodule
